// File: rtl/my_loader_pkg.sv
// ----------------------------------------------------------------------------
// my_loader_pkg
// Shared types and widths for the ROM loader block.
//   ADDR_W          : instruction-ROM address width (15)
//   WORD_W          : instruction word width (16)
//   loader_state_e  : loader FSM state encoding
// Optional feature macro: MY_ROM_LOADER_CHECKSUM_EN adds the checksum states.
// ----------------------------------------------------------------------------
package my_loader_pkg;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
`ifdef MY_ROM_LOADER_CHECKSUM_EN
        ST_CSUM_HI,
        ST_CSUM_LO,
`endif
        ST_DONE,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/my_rom_loader_if.sv
// ----------------------------------------------------------------------------
// my_rom_loader_if
// Groups the byte-stream handshake and the ROM write port of the loader.
//   in_data  [7:0]        : byte stream
//   in_valid              : in_data is valid
//   in_ready              : loader accepts a byte this cycle
//   rom_we                : instruction-ROM write strobe
//   rom_addr [ADDR_W-1:0] : ROM write address
//   rom_data [WORD_W-1:0] : ROM write data
// Modports: master = stream source / ROM observer, slave = the loader.
// ----------------------------------------------------------------------------
interface my_rom_loader_if;
    import my_loader_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, rom_we, rom_addr, rom_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, rom_we, rom_addr, rom_data
    );

endinterface

// File: rtl/my_byte_pair.sv
// ----------------------------------------------------------------------------
// my_byte_pair
// Assembles a big-endian 16-bit word from two accepted bytes. The high byte
// is captured on hi_en_i; on lo_en_i the full word is presented together
// with a one-cycle valid so the caller can register it in the same cycle.
// Used for the length, data and checksum words alike.
//   clk, reset     : clock, synchronous active-high reset
//   byte_i         : incoming byte
//   hi_en_i        : byte_i is a high byte being accepted
//   lo_en_i        : byte_i is a low byte being accepted
//   word_o         : {captured high byte, byte_i}
//   word_valid_o   : word_o is complete this cycle
// ----------------------------------------------------------------------------
module my_byte_pair
    import my_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_i,
    input  logic              hi_en_i,
    input  logic              lo_en_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [7:0] hi_q;
    logic [7:0] hi_d;

    always_comb begin
        hi_d = hi_en_i ? byte_i : hi_q;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    // The low byte is passed straight through so no cycle is lost.
    assign word_o       = {hi_q, byte_i};
    assign word_valid_o = lo_en_i;

endmodule

// File: rtl/my_rom_loader.sv
// ----------------------------------------------------------------------------
// my_rom_loader
// Receives a program over a valid/ready byte stream and writes it into the
// instruction ROM while holding the CPU in reset. Stream format: 16-bit
// length N (high byte first), N data words (high byte first), then a
// checksum word when MY_ROM_LOADER_CHECKSUM_EN is defined (sum mod 2^16 of
// all data words; match -> DONE, mismatch -> ERROR).
//   ROM_WORDS : largest accepted program length in words
//   clk       : clock
//   reset     : synchronous active-high reset
//   start     : one-cycle pulse, honoured in IDLE, DONE or ERROR
//   bus       : my_rom_loader_if.slave (byte stream + ROM write port)
//   busy      : a load is in progress
//   done      : sticky, last load completed successfully
//   error     : sticky, last load failed (too long or bad checksum)
//   cpu_hold  : CPU reset, released only in DONE
// ----------------------------------------------------------------------------
module my_rom_loader
    import my_loader_pkg::*;
#(
    parameter int ROM_WORDS = 32768
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    my_rom_loader_if.slave bus,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic           cpu_hold
);

`ifdef MY_ROM_LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER_DATA = ST_CSUM_HI;
`else
    localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

    loader_state_e     state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       len_q, len_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0] rom_data_q, rom_data_d;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;
`endif

    logic              in_ready;
    logic              fire;
    logic              is_hi;
    logic              is_lo;
    logic [WORD_W-1:0] pair_word;
    logic              pair_valid;

    assign fire = bus.in_valid && in_ready;

    my_byte_pair u_byte_pair (
        .clk          (clk),
        .reset        (reset),
        .byte_i       (bus.in_data),
        .hi_en_i      (fire && is_hi),
        .lo_en_i      (fire && is_lo),
        .word_o       (pair_word),
        .word_valid_o (pair_valid)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            rom_we_q   <= rom_we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rom_we_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    idx_d   = '0;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (fire) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (pair_valid) begin
                    len_d = pair_word;
                    // Rejecting oversize lengths here keeps the word index
                    // below ROM_WORDS, so rom_addr can never wrap.
                    if (32'(pair_word) > 32'(ROM_WORDS)) begin
                        state_d = ST_ERROR;
                    end else if (pair_word == '0) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (fire) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (pair_valid) begin
                    // The write is registered, so the next byte can be
                    // accepted in the same cycle the strobe is high.
                    rom_we_d   = 1'b1;
                    rom_addr_d = idx_q[ADDR_W-1:0];
                    rom_data_d = pair_word;
                    idx_d      = idx_q + 16'd1;
`ifdef MY_ROM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + pair_word;
`endif
                    state_d    = (idx_d == len_q) ? ST_AFTER_DATA : ST_DATA_HI;
                end
            end
`ifdef MY_ROM_LOADER_CHECKSUM_EN
            ST_CSUM_HI: begin
                if (fire) state_d = ST_CSUM_LO;
            end
            ST_CSUM_LO: begin
                if (pair_valid) begin
                    state_d = (pair_word == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs and byte-position decode.
    always_comb begin
        in_ready = 1'b0;
        is_hi    = 1'b0;
        is_lo    = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            ST_LEN_HI, ST_DATA_HI: begin
                in_ready = 1'b1;
                is_hi    = 1'b1;
            end
            ST_LEN_LO, ST_DATA_LO: begin
                in_ready = 1'b1;
                is_lo    = 1'b1;
            end
`ifdef MY_ROM_LOADER_CHECKSUM_EN
            ST_CSUM_HI: begin
                in_ready = 1'b1;
                is_hi    = 1'b1;
            end
            ST_CSUM_LO: begin
                in_ready = 1'b1;
                is_lo    = 1'b1;
            end
`endif
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERROR: begin
                error    = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // The loader accepts bytes exactly in the states where it is busy.
    assign busy         = in_ready;
    assign bus.in_ready = in_ready;
    assign bus.rom_we   = rom_we_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;

endmodule

// File: tb/tb_my_rom_loader.sv
// ----------------------------------------------------------------------------
// tb_my_rom_loader
// Self-checking bench for my_rom_loader. Expected ROM writes are queued as
// each data word is driven and matched against observed writes. Follows the
// build's MY_ROM_LOADER_CHECKSUM_EN setting for the stream format.
// ----------------------------------------------------------------------------
module tb_my_rom_loader;
    import my_loader_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic error;
    logic cpu_hold;

    my_rom_loader_if bus ();

    my_rom_loader #(.ROM_WORDS(32768)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [30:0] sb[$];
    logic        prev_we  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM write monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        logic [30:0] e;
        if (bus.rom_we === 1'b1) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", 32'(bus.rom_addr), 32'(e[30:16]));
                check("write_data", 32'(bus.rom_data), 32'(e[15:0]));
            end
        end
        prev_we = bus.rom_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        if (gaps) begin
            int n = $urandom_range(0, 3);
            repeat (n) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send_word(input logic [14:0] addr, input logic [15:0] w, input bit gaps);
        send_byte(w[15:8], gaps);
        sb.push_back({addr, w});
        send_byte(w[7:0], gaps);
        check("we_latency", 32'(bus.rom_we), 32'd1);
    endtask

    task automatic send_trailer(input logic [15:0] c, input bit gaps);
`ifdef MY_ROM_LOADER_CHECKSUM_EN
        send_byte(c[15:8], gaps);
        send_byte(c[7:0], gaps);
`else
        if (gaps && c == 16'hFFFF) @(posedge clk);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_status(input string t, input logic b, input logic d,
                                input logic e, input logic h);
        check({t, "_busy"},     32'(busy),     32'(b));
        check({t, "_done"},     32'(done),     32'(d));
        check({t, "_error"},    32'(error),    32'(e));
        check({t, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    endtask

    task automatic check_reset_vals(input string t);
        check_status(t, 1'b0, 1'b0, 1'b0, 1'b1);
        check({t, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({t, "_rom_we"},   32'(bus.rom_we),   32'd0);
        check({t, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({t, "_rom_data"}, 32'(bus.rom_data), 32'd0);
    endtask

    // One idle cycle lets the monitor retire the last write before draining.
    task automatic settle_and_drain(input string t);
        @(posedge clk); #1;
        check({t, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] w[3];
        logic [15:0] sum;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("reset");

        // in_valid while IDLE must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (4) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check_status("idle_valid", 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic two-word load, back-to-back bytes.
        pulse_start();
        check_status("started", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(15'd0, 16'h1234, 1'b0);
        send_word(15'd1, 16'hABCD, 1'b0);
        send_trailer(16'hBE01, 1'b0);
        check_status("load_a", 1'b0, 1'b1, 1'b0, 1'b0);
        settle_and_drain("load_a");
        check_status("load_a_sticky", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef MY_ROM_LOADER_CHECKSUM_EN
        // Bad checksum: words still written, then ERROR.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(15'd0, 16'h1234, 1'b0);
        send_word(15'd1, 16'hABCD, 1'b0);
        send_trailer(16'hBE02, 1'b0);
        check_status("bad_csum", 1'b0, 1'b0, 1'b1, 1'b1);
        settle_and_drain("bad_csum");
`endif

        // Oversize length 32769 -> ERROR right after the length.
        pulse_start();
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b0);
        check_status("too_long", 1'b0, 1'b0, 1'b1, 1'b1);
        check("too_long_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("too_long_no_write", 32'(sb.size()), 32'd0);

        // Length exactly ROM_WORDS is accepted; abort it with reset.
        pulse_start();
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("max_len", 1'b1, 1'b0, 1'b0, 1'b1);
        send_word(15'd0, 16'h0F0F, 1'b0);
        do_reset();
        check_reset_vals("max_len_reset");
        settle_and_drain("max_len");

        // Zero-length program.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_trailer(16'h0000, 1'b0);
        check_status("zero_len", 1'b0, 1'b1, 1'b0, 1'b0);
        settle_and_drain("zero_len");

        // Three random words with random in_valid gaps.
        sum = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            sum  = sum + w[i];
        end
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 3; i++) send_word(15'(i), w[i], 1'b1);
        send_trailer(sum, 1'b1);
        check_status("gappy", 1'b0, 1'b1, 1'b0, 1'b0);
        settle_and_drain("gappy");

        // Reset after the first word: no further writes.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(15'd0, 16'h5A5A, 1'b0);
        do_reset();
        check_reset_vals("mid_reset");
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i * 37);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check_reset_vals("mid_reset_after");
        settle_and_drain("mid_reset");

        // start while busy is ignored.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(15'd0, 16'h1111, 1'b0);
        pulse_start();
        check_status("start_busy", 1'b1, 1'b0, 1'b0, 1'b1);
        send_word(15'd1, 16'h2222, 1'b0);
        send_trailer(16'h3333, 1'b0);
        check_status("start_busy_end", 1'b0, 1'b1, 1'b0, 1'b0);
        settle_and_drain("start_busy");

        // Restart from DONE: new load from address 0.
        pulse_start();
        check_status("restart", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(15'd0, 16'hC0DE, 1'b0);
        send_trailer(16'hC0DE, 1'b0);
        check_status("restart_end", 1'b0, 1'b1, 1'b0, 1'b0);
        settle_and_drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/my_rom_loader.md
MY_ROM_LOADER -- requirements
Module: my_rom_loader

Interface
REQ-001 Parameter ROM_WORDS, default 32768, SHALL set the maximum accepted program length in words.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL be a one-cycle pulse that begins a load; it is honoured only in IDLE, DONE or ERROR.
REQ-005 in_data  input  8  SHALL carry the byte stream.
REQ-006 in_valid  input  1  SHALL mark in_data as valid.
REQ-007 in_ready  output  1  SHALL signal that the loader accepts a byte this cycle.
REQ-008 rom_we  output  1  SHALL be the instruction-ROM write strobe.
REQ-009 rom_addr  output  15  SHALL be the ROM write address.
REQ-010 rom_data  output  16  SHALL be the ROM write data.
REQ-011 cpu_hold  output  1  SHALL be driven to the CPU reset input.
REQ-012 busy, done, error  output  1 each  SHALL report loader status.

Function
REQ-013 A byte SHALL transfer exactly when in_valid && in_ready on posedge clk; in_valid without in_ready SHALL be ignored.
REQ-014 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR.
REQ-015 The stream format SHALL be: 16-bit length N (high byte first), then N words (high byte first each), then one checksum word only when REQ-029 applies.
REQ-016 in_ready SHALL be 1 exactly in states LEN_HI through CSUM_LO.
REQ-017 start SHALL move IDLE/DONE/ERROR to LEN_HI, clear the word counter and checksum, and clear done and error.
REQ-018 If N > ROM_WORDS after LEN_LO, the FSM SHALL go to ERROR.
REQ-019 If N == 0, the FSM SHALL go directly to CSUM_HI when checksum is enabled, else to DONE.
REQ-020 On the DATA_LO byte, the FSM SHALL register rom_we=1, rom_addr=word index, rom_data={hi,lo} for exactly the next cycle, then increment the index.
REQ-021 Back-to-back bytes SHALL sustain 1 byte/cycle, i.e. one ROM write every 2 cycles; no stall is inserted for the write.
REQ-022 After word N-1, the FSM SHALL go to CSUM_HI when checksum is enabled, else to DONE.
REQ-023 rom_addr SHALL never wrap; REQ-018 bounds the index to ROM_WORDS-1.
REQ-024 busy SHALL be 1 in LEN_HI..CSUM_LO.
REQ-025 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR; both SHALL be sticky until start or reset.
REQ-026 cpu_hold SHALL be 1 in every state except DONE.
REQ-027 start asserted while busy SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, rom_we=0, rom_addr=0, rom_data=0, in_ready=0, busy=0, done=0, error=0, cpu_hold=1. Reset mid-load SHALL abort with no further writes; words already written remain in ROM.

Configuration
REQ-029 With MY_ROM_LOADER_CHECKSUM_EN defined, the loader SHALL accumulate sum mod 2^16 of all data words, read a trailing checksum word, and go to DONE on match or ERROR on mismatch. Without it, CSUM_HI/CSUM_LO and the accumulator SHALL be absent, and DONE SHALL follow the last word.

Structure
REQ-030 A shared package my_loader_pkg SHALL hold the state enum typedef, the address width (15) and the word width (16).
REQ-031 One sub-module, my_byte_pair, SHALL assemble the high/low bytes into a 16-bit word with a valid pulse; it is reused for length, data and checksum.

Verification
REQ-032 Reset, then start, then stream 00 02 | 12 34 | AB CD (checksum off) -> writes (0,1234) then (1,ABCD); done=1; cpu_hold=0.
REQ-033 Checksum on, same stream plus BE 01 -> done=1. Same stream plus BE 02 -> error=1, cpu_hold=1, and both words are still written.
REQ-034 Length 80 01 (32769) -> ERROR right after LEN_LO; no rom_we.
REQ-035 Length 00 00 (checksum off) -> DONE with no writes. With checksum on, a trailing 00 00 -> DONE.
REQ-036 Toggle in_valid randomly during a 3-word load -> identical write sequence. Assert reset after the first word -> no further rom_we, and all outputs at reset values.
REQ-037 start pulsed while busy -> ignored. start pulsed from DONE -> new load begins at address 0.
